// File: rtl/tl_pkg.sv
// Shared phase codes and lamp encodings for the traffic light controller.
package tl_pkg;

    typedef enum logic [2:0] {
        PH_ALL_RED_A = 3'd0,
        PH_NS_GREEN  = 3'd1,
        PH_NS_YELLOW = 3'd2,
        PH_ALL_RED_B = 3'd3,
        PH_EW_GREEN  = 3'd4,
        PH_EW_YELLOW = 3'd5,
        PH_PED_WALK  = 3'd6,
        PH_UNUSED    = 3'd7
    } phase_t;

    localparam logic [2:0] LIGHT_RED    = 3'b100;
    localparam logic [2:0] LIGHT_YELLOW = 3'b010;
    localparam logic [2:0] LIGHT_GREEN  = 3'b001;

endpackage

// File: rtl/traffic_light_controller_phase_timer.sv
// Dwell counter: counts ticks within a phase, flags expiry on the last tick,
// optionally parks at the terminal count instead of wrapping.
module phase_timer #(
    parameter int unsigned TIMER_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 tick,
    input  logic [TIMER_WIDTH:0] duration,
    input  logic                 saturate,
    output logic                 expire
);

    localparam int unsigned DW = TIMER_WIDTH + 1;

    logic [TIMER_WIDTH-1:0] count_q;
    logic [TIMER_WIDTH-1:0] count_d;
    logic                   at_end;

    // duration is one bit wider so a duration of 2**TIMER_WIDTH still compares cleanly
    assign at_end = ({1'b0, count_q} == (duration - DW'(1)));
    assign expire = tick & at_end;

    // Next count: clear on phase entry, advance on tick, park or wrap at the end
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (tick) begin
            if (!at_end) begin
                count_d = count_q + TIMER_WIDTH'(1);
            end else if (!saturate) begin
                count_d = '0;
            end
        end
    end

    // Count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/traffic_light_controller.sv
// Two-way intersection sequencer with optional pedestrian walk phase.
// Optional feature macro: TLC_PED_WALK_EN (pedestrian latch and PED_WALK phase).
module traffic_light_controller
    import tl_pkg::*;
#(
    parameter int unsigned GREEN_CYCLES  = 8,
    parameter int unsigned YELLOW_CYCLES = 3,
    parameter int unsigned ALLRED_CYCLES = 1,
    parameter int unsigned WALK_CYCLES   = 4,
    parameter int unsigned TIMER_WIDTH   = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       ew_car,
    input  logic       ped_req,
    output logic [2:0] ns_light,
    output logic [2:0] ew_light,
    output logic       walk,
    output logic [2:0] phase,
    output logic       ped_pending
);

    localparam int unsigned DW = TIMER_WIDTH + 1;

    phase_t        phase_q;
    phase_t        phase_d;
    logic [DW-1:0] duration;
    logic          saturate;
    logic          expire;
    logic          timer_clear;
    logic          ped_q;

    // Next phase, dwell selection and timer controls
    always_comb begin
        phase_d  = phase_q;
        duration = DW'(ALLRED_CYCLES);
        saturate = 1'b0;
        case (phase_q)
            PH_ALL_RED_A: begin
                duration = DW'(ALLRED_CYCLES);
                if (expire) phase_d = ped_q ? PH_PED_WALK : PH_NS_GREEN;
            end
            PH_NS_GREEN: begin
                duration = DW'(GREEN_CYCLES);
                saturate = 1'b1;
                if (expire && (ew_car || ped_q)) phase_d = PH_NS_YELLOW;
            end
            PH_NS_YELLOW: begin
                duration = DW'(YELLOW_CYCLES);
                if (expire) phase_d = PH_ALL_RED_B;
            end
            PH_ALL_RED_B: begin
                duration = DW'(ALLRED_CYCLES);
                if (expire) phase_d = PH_EW_GREEN;
            end
            PH_EW_GREEN: begin
                duration = DW'(GREEN_CYCLES);
                if (expire) phase_d = PH_EW_YELLOW;
            end
            PH_EW_YELLOW: begin
                duration = DW'(YELLOW_CYCLES);
                if (expire) phase_d = PH_ALL_RED_A;
            end
            PH_PED_WALK: begin
                duration = DW'(WALK_CYCLES);
                if (expire) phase_d = PH_NS_GREEN;
            end
            default: begin
                phase_d = PH_ALL_RED_A;
            end
        endcase
        timer_clear = (phase_d != phase_q);
    end

    phase_timer #(
        .TIMER_WIDTH(TIMER_WIDTH)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (timer_clear),
        .tick    (tick),
        .duration(duration),
        .saturate(saturate),
        .expire  (expire)
    );

    // Phase register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= PH_ALL_RED_A;
        end else begin
            phase_q <= phase_d;
        end
    end

`ifdef TLC_PED_WALK_EN
    logic walk_entry;
    assign walk_entry = (phase_d == PH_PED_WALK) && (phase_q != PH_PED_WALK);

    // Pedestrian latch: a new request on the entry edge wins over the clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ped_q <= 1'b0;
        end else begin
            ped_q <= ped_req | (ped_q & ~walk_entry);
        end
    end
`else
    logic unused_ped_req;
    assign unused_ped_req = ped_req;
    assign ped_q          = 1'b0;
`endif

    // Moore lamp decode; anything not a green/yellow phase shows red
    always_comb begin
        ns_light = LIGHT_RED;
        ew_light = LIGHT_RED;
        walk     = 1'b0;
        case (phase_q)
            PH_NS_GREEN:  ns_light = LIGHT_GREEN;
            PH_NS_YELLOW: ns_light = LIGHT_YELLOW;
            PH_EW_GREEN:  ew_light = LIGHT_GREEN;
            PH_EW_YELLOW: ew_light = LIGHT_YELLOW;
`ifdef TLC_PED_WALK_EN
            PH_PED_WALK:  walk = 1'b1;
`endif
            default: ;
        endcase
    end

    assign phase       = phase_q;
    assign ped_pending = ped_q;

endmodule
